// File: rtl/int_controller.sv
// Vectored interrupt controller: edge-latched hardware sources plus a software
// request, one-cycle dispatch/return redirect pulses and a saved EPC/cause.
module int_controller #(
    parameter int unsigned NSRC   = 4,
    parameter logic [15:0] VECTOR = 16'h0004
) (
    input  logic            icti_clk,
    input  logic            icti_rst,
    input  logic [NSRC-1:0] icti_irq,
    input  logic [NSRC-1:0] icti_mask,
    input  logic            icti_glb_en,
    input  logic            icti_soft_int,
    input  logic [3:0]      icti_soft_id,
    input  logic            icti_eret,
    input  logic [15:0]     icti_epc,
    input  logic            icti_in_bds,
    input  logic            icti_is_branch,
    output logic            icto_set_pc,
    output logic [15:0]     icto_target,
    output logic [15:0]     icto_epc,
    output logic [3:0]      icto_ecause,
    output logic            icto_busy,
    output logic [NSRC-1:0] icto_pending,
    output logic [NSRC-1:0] icto_ack
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DISPATCH,
        S_HANDLING,
        S_RETURN
    } state_t;

    state_t          state, state_n;
    logic [NSRC-1:0] irq_q;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] masked;
    logic [NSRC-1:0] grant;
    logic [2:0]      grant_idx;
    logic            soft_go;
    logic            hw_go;
    logic [15:0]     hw_epc;

    assign rise   = icti_irq & ~irq_q;
    assign masked = pending & icti_mask;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (masked[i] && (grant == '0)) begin
                grant[i]  = 1'b1;
                grant_idx = 3'(i);
            end
        end
    end

    // Delay-slot faults restart at the branch, branches re-execute, others resume after.
    always_comb begin
        if (icti_in_bds)
            hw_epc = icti_epc - 16'd1;
        else if (icti_is_branch)
            hw_epc = icti_epc;
        else
            hw_epc = icti_epc + 16'd1;
    end

    always_comb begin
        state_n = state;
        soft_go = 1'b0;
        hw_go   = 1'b0;
        case (state)
            S_IDLE: begin
                if (icti_soft_int) begin
                    soft_go = 1'b1;
                    state_n = S_DISPATCH;
                end else if (icti_glb_en && (masked != '0)) begin
                    hw_go   = 1'b1;
                    state_n = S_DISPATCH;
                end
            end
            S_DISPATCH: state_n = S_HANDLING;
            S_HANDLING: if (icti_eret) state_n = S_RETURN;
            S_RETURN:   state_n = S_IDLE;
            default:    state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge icti_clk) begin
        if (icti_rst) begin
            state       <= S_IDLE;
            irq_q       <= '0;
            pending     <= '0;
            icto_ack    <= '0;
            icto_epc    <= '0;
            icto_ecause <= '0;
        end else begin
            state    <= state_n;
            irq_q    <= icti_irq;
            // A fresh edge wins over the dispatch clear so it is not lost.
            pending  <= (pending & ~(hw_go ? grant : '0)) | rise;
            icto_ack <= hw_go ? grant : '0;
            if (soft_go) begin
                icto_epc    <= icti_epc + 16'd1;
                icto_ecause <= icti_soft_id;
            end else if (hw_go) begin
                icto_epc    <= hw_epc;
                icto_ecause <= 4'h8 + {1'b0, grant_idx};
            end else if ((state == S_HANDLING) && icti_eret) begin
                icto_ecause <= '0;
            end
        end
    end

    always_comb begin
        icto_set_pc = 1'b0;
        icto_target = '0;
        case (state)
            S_DISPATCH: begin
                icto_set_pc = 1'b1;
                icto_target = VECTOR;
            end
            S_RETURN: begin
                icto_set_pc = 1'b1;
                icto_target = icto_epc;
            end
            default: ;
        endcase
    end

    assign icto_busy    = (state != S_IDLE);
    assign icto_pending = pending;

endmodule

// File: tb/tb_int_controller.sv
// Directed self-checking bench for int_controller (NSRC=4, VECTOR=16'h0004).
module tb_int_controller;

    logic        clk;
    logic        rst;
    logic [3:0]  irq;
    logic [3:0]  mask;
    logic        glb_en;
    logic        soft_int;
    logic [3:0]  soft_id;
    logic        eret;
    logic [15:0] epc_in;
    logic        in_bds;
    logic        is_branch;
    logic        set_pc;
    logic [15:0] target;
    logic [15:0] epc_out;
    logic [3:0]  ecause;
    logic        busy;
    logic [3:0]  pending;
    logic [3:0]  ack;

    int checks;
    int failures;

    int_controller #(
        .NSRC(4),
        .VECTOR(16'h0004)
    ) dut (
        .icti_clk      (clk),
        .icti_rst      (rst),
        .icti_irq      (irq),
        .icti_mask     (mask),
        .icti_glb_en   (glb_en),
        .icti_soft_int (soft_int),
        .icti_soft_id  (soft_id),
        .icti_eret     (eret),
        .icti_epc      (epc_in),
        .icti_in_bds   (in_bds),
        .icti_is_branch(is_branch),
        .icto_set_pc   (set_pc),
        .icto_target   (target),
        .icto_epc      (epc_out),
        .icto_ecause   (ecause),
        .icto_busy     (busy),
        .icto_pending  (pending),
        .icto_ack      (ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walks DISPATCH -> HANDLING -> RETURN -> IDLE with an eret in HANDLING.
    task automatic finish_handler();
        tick();
        eret = 1'b1;
        tick();
        eret = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; irq = '0; mask = '0; glb_en = 1'b0; soft_int = 1'b0; soft_id = '0;
        eret = 1'b0; epc_in = '0; in_bds = 1'b0; is_branch = 1'b0;
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        checks++; if (set_pc !== 1'b0) begin failures++; $display("FAIL rst_set_pc got=%0b exp=0", set_pc); end
        checks++; if (target !== 16'h0000) begin failures++; $display("FAIL rst_target got=%h exp=0000", target); end
        checks++; if (pending !== 4'b0000) begin failures++; $display("FAIL rst_pending got=%b exp=0000", pending); end
        checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL rst_ack got=%b exp=0000", ack); end
        checks++; if (epc_out !== 16'h0000) begin failures++; $display("FAIL rst_epc got=%h exp=0000", epc_out); end
        checks++; if (ecause !== 4'h0) begin failures++; $display("FAIL rst_ecause got=%h exp=0", ecause); end
        rst = 1'b0;
    endtask

    task automatic test_hw_dispatch();
        mask = 4'hF; glb_en = 1'b1; epc_in = 16'h0100; irq = 4'b0100;
        tick();
        checks++; if (pending !== 4'b0100) begin failures++; $display("FAIL hw_pending got=%b exp=0100", pending); end
        checks++; if (set_pc !== 1'b0) begin failures++; $display("FAIL hw_early_set_pc got=%0b exp=0", set_pc); end
        tick();
        checks++; if (set_pc !== 1'b1) begin failures++; $display("FAIL hw_set_pc got=%0b exp=1", set_pc); end
        checks++; if (target !== 16'h0004) begin failures++; $display("FAIL hw_target got=%h exp=0004", target); end
        checks++; if (ecause !== 4'hA) begin failures++; $display("FAIL hw_ecause got=%h exp=a", ecause); end
        checks++; if (epc_out !== 16'h0101) begin failures++; $display("FAIL hw_epc got=%h exp=0101", epc_out); end
        checks++; if (ack !== 4'b0100) begin failures++; $display("FAIL hw_ack got=%b exp=0100", ack); end
        checks++; if (pending !== 4'b0000) begin failures++; $display("FAIL hw_pending_clr got=%b exp=0000", pending); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL hw_busy got=%0b exp=1", busy); end
        tick();
        checks++; if (set_pc !== 1'b0) begin failures++; $display("FAIL hw_handling_set_pc got=%0b exp=0", set_pc); end
        checks++; if (target !== 16'h0000) begin failures++; $display("FAIL hw_handling_target got=%h exp=0000", target); end
        checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL hw_ack_drop got=%b exp=0000", ack); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL hw_handling_busy got=%0b exp=1", busy); end
        checks++; if (ecause !== 4'hA) begin failures++; $display("FAIL hw_ecause_hold got=%h exp=a", ecause); end
        eret = 1'b1;
        tick();
        eret = 1'b0;
        checks++; if (set_pc !== 1'b1) begin failures++; $display("FAIL hw_ret_set_pc got=%0b exp=1", set_pc); end
        checks++; if (target !== 16'h0101) begin failures++; $display("FAIL hw_ret_target got=%h exp=0101", target); end
        checks++; if (ecause !== 4'h0) begin failures++; $display("FAIL hw_ret_ecause got=%h exp=0", ecause); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hw_idle_busy got=%0b exp=0", busy); end
        checks++; if (set_pc !== 1'b0) begin failures++; $display("FAIL hw_idle_set_pc got=%0b exp=0", set_pc); end
        irq = '0;
        tick();
    endtask

    task automatic test_epc_modes();
        in_bds = 1'b1; epc_in = 16'h0000; irq = 4'b0001;
        tick();
        tick();
        checks++; if (epc_out !== 16'hFFFF) begin failures++; $display("FAIL bds_epc got=%h exp=ffff", epc_out); end
        checks++; if (ecause !== 4'h8) begin failures++; $display("FAIL bds_ecause got=%h exp=8", ecause); end
        finish_handler();
        in_bds = 1'b0; is_branch = 1'b1; epc_in = 16'h1234; irq = 4'b1001;
        tick();
        tick();
        checks++; if (epc_out !== 16'h1234) begin failures++; $display("FAIL branch_epc got=%h exp=1234", epc_out); end
        checks++; if (ecause !== 4'hB) begin failures++; $display("FAIL branch_ecause got=%h exp=b", ecause); end
        finish_handler();
        is_branch = 1'b0; irq = '0;
        tick();
    endtask

    task automatic test_priority();
        glb_en = 1'b0; irq = 4'b0011;
        tick();
        checks++; if (pending !== 4'b0011) begin failures++; $display("FAIL prio_pending got=%b exp=0011", pending); end
        glb_en = 1'b1; soft_int = 1'b1; soft_id = 4'h3; epc_in = 16'h0200;
        tick();
        soft_int = 1'b0;
        checks++; if (ecause !== 4'h3) begin failures++; $display("FAIL prio_soft_ecause got=%h exp=3", ecause); end
        checks++; if (epc_out !== 16'h0201) begin failures++; $display("FAIL prio_soft_epc got=%h exp=0201", epc_out); end
        checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL prio_soft_ack got=%b exp=0000", ack); end
        checks++; if (pending !== 4'b0011) begin failures++; $display("FAIL prio_soft_pending got=%b exp=0011", pending); end
        tick();
        soft_int = 1'b1; soft_id = 4'h5;
        tick();
        soft_int = 1'b0;
        checks++; if (ecause !== 4'h3) begin failures++; $display("FAIL prio_soft_ignored got=%h exp=3", ecause); end
        checks++; if (set_pc !== 1'b0) begin failures++; $display("FAIL prio_handling_set_pc got=%0b exp=0", set_pc); end
        eret = 1'b1;
        tick();
        eret = 1'b0;
        checks++; if (target !== 16'h0201) begin failures++; $display("FAIL prio_ret_target got=%h exp=0201", target); end
        tick();
        tick();
        checks++; if (ecause !== 4'h8) begin failures++; $display("FAIL prio_src0_ecause got=%h exp=8", ecause); end
        checks++; if (ack !== 4'b0001) begin failures++; $display("FAIL prio_src0_ack got=%b exp=0001", ack); end
        checks++; if (pending !== 4'b0010) begin failures++; $display("FAIL prio_src0_pending got=%b exp=0010", pending); end
        finish_handler();
        tick();
        checks++; if (ecause !== 4'h9) begin failures++; $display("FAIL prio_src1_ecause got=%h exp=9", ecause); end
        checks++; if (ack !== 4'b0010) begin failures++; $display("FAIL prio_src1_ack got=%b exp=0010", ack); end
        finish_handler();
        irq = '0;
        tick();
    endtask

    task automatic test_masking();
        glb_en = 1'b0; irq = 4'b0010;
        tick();
        checks++; if (pending !== 4'b0010) begin failures++; $display("FAIL mask_pending got=%b exp=0010", pending); end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (set_pc !== 1'b0) begin failures++; $display("FAIL mask_glb_hold got=%0b exp=0 cycle=%0d", set_pc, i); end
        end
        glb_en = 1'b1;
        tick();
        checks++; if (set_pc !== 1'b1) begin failures++; $display("FAIL mask_release_set_pc got=%0b exp=1", set_pc); end
        checks++; if (ecause !== 4'h9) begin failures++; $display("FAIL mask_release_ecause got=%h exp=9", ecause); end
        finish_handler();
        irq = '0; mask = 4'b1110;
        tick();
        irq = 4'b0001;
        tick();
        tick();
        checks++; if (set_pc !== 1'b0) begin failures++; $display("FAIL mask_src_hold got=%0b exp=0", set_pc); end
        checks++; if (pending !== 4'b0001) begin failures++; $display("FAIL mask_src_pending got=%b exp=0001", pending); end
        mask = 4'hF;
        tick();
        checks++; if (ecause !== 4'h8) begin failures++; $display("FAIL mask_src_release got=%h exp=8", ecause); end
        finish_handler();
        irq = '0;
        tick();
    endtask

    task automatic test_same_cycle_edge();
        glb_en = 1'b0; irq = 4'b0001;
        tick();
        irq = '0;
        tick();
        glb_en = 1'b1; irq = 4'b0001;
        tick();
        checks++; if (ack !== 4'b0001) begin failures++; $display("FAIL same_ack got=%b exp=0001", ack); end
        checks++; if (pending !== 4'b0001) begin failures++; $display("FAIL same_pending got=%b exp=0001", pending); end
        finish_handler();
        tick();
        checks++; if (set_pc !== 1'b1) begin failures++; $display("FAIL same_redispatch got=%0b exp=1", set_pc); end
        checks++; if (pending !== 4'b0000) begin failures++; $display("FAIL same_pending_clr got=%b exp=0000", pending); end
        finish_handler();
        irq = '0;
        tick();
    endtask

    task automatic test_reset_mid_handler();
        irq = 4'b0100;
        tick();
        tick();
        tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_pre got=%0b exp=1", busy); end
        irq = 4'b0110;
        tick();
        checks++; if (pending !== 4'b0010) begin failures++; $display("FAIL midrst_latch got=%b exp=0010", pending); end
        rst = 1'b1; irq = '0;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%0b exp=0", busy); end
        checks++; if (pending !== 4'b0000) begin failures++; $display("FAIL midrst_pending got=%b exp=0000", pending); end
        checks++; if (set_pc !== 1'b0) begin failures++; $display("FAIL midrst_set_pc got=%0b exp=0", set_pc); end
        checks++; if (ecause !== 4'h0) begin failures++; $display("FAIL midrst_ecause got=%h exp=0", ecause); end
        eret = 1'b1;
        tick();
        eret = 1'b0;
        checks++; if (set_pc !== 1'b0) begin failures++; $display("FAIL midrst_eret_set_pc got=%0b exp=0", set_pc); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_eret_busy got=%0b exp=0", busy); end
        glb_en = 1'b0; rst = 1'b1; irq = 4'b1000;
        tick();
        rst = 1'b0;
        tick();
        checks++; if (pending !== 4'b1000) begin failures++; $display("FAIL rst_level_edge got=%b exp=1000", pending); end
        glb_en = 1'b1;
        tick();
        checks++; if (ecause !== 4'hB) begin failures++; $display("FAIL rst_level_dispatch got=%h exp=b", ecause); end
        finish_handler();
        irq = '0;
        tick();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_hw_dispatch();
        test_epc_modes();
        test_priority();
        test_masking();
        test_same_cycle_edge();
        test_reset_mid_handler();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/int_controller.md
INT_CONTROLLER -- requirements
Module: int_controller

Interface
REQ-001 The block SHALL take parameter NSRC, default 4, as the number of hardware interrupt sources (1..8).
REQ-002 The block SHALL take parameter VECTOR, default 16'h0004, as the handler entry address.
REQ-003 The block SHALL have port icti_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port icti_rst, input, 1 bit: synchronous reset, active-high.
REQ-005 The block SHALL have port icti_irq, input, NSRC bits: hardware interrupt request lines, rising-edge significant.
REQ-006 The block SHALL have port icti_mask, input, NSRC bits: per-source enable; 1 means enabled.
REQ-007 The block SHALL have port icti_glb_en, input, 1 bit: global interrupt enable.
REQ-008 The block SHALL have ports icti_soft_int (input, 1 bit) and icti_soft_id (input, 4 bits): software interrupt request and its cause code.
REQ-009 The block SHALL have port icti_eret, input, 1 bit: return-from-handler request.
REQ-010 The block SHALL have ports icti_epc (input, 16 bits), icti_in_bds (input, 1 bit) and icti_is_branch (input, 1 bit): current ID-stage PC, delay-slot flag and branch flag.
REQ-011 The block SHALL have ports icto_set_pc (output, 1 bit) and icto_target (output, 16 bits): PC redirect pulse and redirect address.
REQ-012 The block SHALL have ports icto_epc (output, 16 bits) and icto_ecause (output, 4 bits): saved return address and cause.
REQ-013 The block SHALL have ports icto_busy (output, 1 bit), icto_pending (output, NSRC bits) and icto_ack (output, NSRC bits): handler active, latched pending bits, and one-hot acknowledge to the source.

Function
REQ-014 Rising-edge detection SHALL work as follows: a registered copy irq_q of icti_irq is kept; at any clock edge where icti_irq[i]=1 and irq_q[i]=0, pending[i] SHALL be set, regardless of mask, glb_en or state.
REQ-015 The FSM SHALL have four states: IDLE, DISPATCH, HANDLING and RETURN.
REQ-016 In IDLE with icti_soft_int=1, the next state SHALL be DISPATCH, with ecause=icti_soft_id and epc=icti_epc+1.
REQ-017 In IDLE with icti_soft_int=0, icti_glb_en=1 and (pending & mask)!=0, the next state SHALL be DISPATCH for the lowest-index source i.
REQ-018 On that hardware dispatch, ecause SHALL be 4'h8+i, pending[i] SHALL be cleared, and icto_ack[i] SHALL be 1 for exactly the DISPATCH cycle.
REQ-019 For hardware dispatch, epc SHALL be: icti_epc-1 if icti_in_bds=1; else icti_epc if icti_is_branch=1; else icti_epc+1; all arithmetic modulo 2^16.
REQ-020 The priority order SHALL be: soft interrupt first, then hardware source 0 through source NSRC-1.
REQ-021 DISPATCH SHALL last exactly one cycle with icto_set_pc=1 and icto_target=VECTOR, then go to HANDLING.
REQ-022 In HANDLING, icto_busy SHALL be 1; icti_eret=1 SHALL move the state to RETURN; soft and hardware requests SHALL be ignored, but hardware pending bits SHALL continue to latch.
REQ-023 RETURN SHALL last exactly one cycle with icto_set_pc=1, icto_target=icto_epc and icto_ecause=0, then go to IDLE.
REQ-024 icto_set_pc SHALL be Moore: 1 only in DISPATCH and RETURN; icto_target SHALL be 0 in all other states.
REQ-025 icto_busy SHALL be 1 in DISPATCH, HANDLING and RETURN.
REQ-026 Latency: for an irq rising edge sampled at edge E0, pending SHALL be visible after E0, DISPATCH SHALL be entered at E1, and icto_set_pc SHALL be high during cycle E1..E2 (if IDLE, enabled and unmasked).
REQ-027 For a soft interrupt sampled at edge E0, DISPATCH SHALL be entered at E0.
REQ-028 A new edge on source i in the same cycle it is cleared by dispatch SHALL leave pending[i]=1.
REQ-029 icti_eret outside HANDLING SHALL be ignored.
REQ-030 While icti_glb_en=0 or the source is masked, pending bits SHALL be held and not dispatched; they SHALL dispatch once enabled.
REQ-031 icto_epc and icto_ecause SHALL hold their latched values from DISPATCH through HANDLING.

Reset
REQ-032 While icti_rst=1 at a clock edge, the block SHALL set: state=IDLE, pending=0, irq_q=0, icto_epc=0, icto_ecause=0, icto_set_pc=0, icto_target=0, icto_busy=0, icto_ack=0.
REQ-033 Reset in any state, including mid-HANDLING, SHALL abandon the handler with no RETURN pulse.
REQ-034 A level-high irq present when reset deasserts SHALL be detected as an edge.

Verification
REQ-035 Directed test, hardware dispatch: mask=4'hF, glb_en=1, icti_epc=16'h0100, no bds or branch, irq[2] rises -> set_pc 2 cycles later, target=16'h0004, ecause=4'hA, epc=16'h0101, ack=4'b0100 for one cycle.
REQ-036 Directed test, delay slot: in_bds=1, epc=16'h0000, irq[0] rises -> icto_epc=16'hFFFF (wrap), ecause=4'h8.
REQ-037 Directed test, priority: soft_int(id=4'h3) with pending=4'b0011 -> soft dispatched first (ecause 3); after eret and RETURN (target=saved epc), source 0 dispatches, then source 1.
REQ-038 Directed test, masking: glb_en=0 with irq[1] edge -> pending=4'b0010 and no set_pc for 10 cycles; glb_en=1 -> dispatch with ecause=4'h9.
REQ-039 Directed test, reset mid-handler: rst pulsed during HANDLING -> busy=0, pending=0, no set_pc; eret after reset is ignored.
